grant_responder: RTL and testbench
==================================

// Module: grant_responder
// PURPOSE
// - Resource-side partner of the round-robin arbiter: consumes its one-hot grant, holds the
//   shared resource for a per-requester burst length, then returns a one-cycle ack pulse.
// - That ack advances the arbiter's rotating priority. A per-requester done pulse tells the
//   winner its burst is finished.
// PARAMETERS
// - N      4  number of requesters (grant/done width)
// - CNT_W  4  width of each burst-length field and of the internal down-counter
// PORTS
// - clock      in   1        single clock, rising edge
// - reset      in   1        asynchronous, active-high; clears all state
// - grant      in   N        one-hot grant from arbiter (combinational on arbiter side)
// - burst_len  in   N*CNT_W  field i = burst length for requester i (0 treated as 1)
// - ack        out  1        registered; 1-cycle pulse at end of each burst
// - busy       out  1        registered; high while resource is owned (SERVE)
// - owner      out  N        registered one-hot copy of the latched grant; 0 when idle
// - done       out  N        registered; done[owner] pulses in the same cycle as ack
// - err        out  1        sticky protocol-error flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: ack=0, busy=0, owner=0, done=0, err=0, state=IDLE, cnt=0.
// - FSM states IDLE, SERVE, ACK. All outputs come from flops.
// - IDLE: grant sampled each edge.
//   - grant==0: stay in IDLE.
//   - Valid grant: owner<=grant; cnt<=max(len_i,1)-1; go to SERVE.
// - SERVE: busy=1.
//   - cnt!=0: cnt<=cnt-1; stay in SERVE.
//   - cnt==0: go to ACK.
//   - Grant changes or drops during SERVE are ignored; ownership is latched.
// - ACK: ack=1 and done[owner]=1 for exactly one cycle; busy=0; owner<=0; next state IDLE.
//   - grant is ignored in ACK, because the arbiter rotates priority on this edge.
// - Latency: grant sampled in IDLE at cycle 0 -> busy in cycles 1..L -> ack in cycle L+1.
//   - Next grant is sampled in cycle L+2 at the earliest.
// - burst_len field is sampled only at acceptance; later changes have no effect.
//   - Max burst = 2^CNT_W-1 cycles; len=0 behaves as len=1.
// - Reset asserted mid-burst: state returns to IDLE immediately (async).
//   - No ack or done is issued for the aborted burst.
// CONFIGURATION
// - Macro GRANT_CHECK_EN.
// - Defined:
//   - A multi-hot grant in IDLE is NOT accepted: stay in IDLE and set err.
//   - Any change of grant away from owner during SERVE sets err (burst still completes).
//   - err clears only on reset.
// - Undefined:
//   - err tied to 0.
//   - A multi-hot grant is accepted as its lowest-index set bit.
// STRUCTURE
// - Package grant_responder_pkg:
//   - typedef enum logic[1:0] {IDLE,SERVE,ACK} resp_state_t
//   - localparam int unsigned RESP_N=4, RESP_CNT_W=4
// - One sub-module, burst_down_counter (CNT_W): load, decrement, zero flag; async reset.
// - Top level holds the FSM, owner/ack/done/err flops, and the one-hot/lowest-bit select.
// TESTING
// - T1 Single burst: len0=3, grant=0001 at cycle 0.
//   - Expect busy in cycles 1-3, ack=1 and done=0001 in cycle 4, owner=0001 in cycles 1-3.
// - T2 Zero length: len2=0, grant=0100.
//   - Expect busy in cycle 1 only, ack and done=0100 in cycle 2.
// - T3 Grant dropped mid-burst: len1=4, grant=0010 then grant=0000 at cycle 2.
//   - Expect busy in cycles 1-4, ack in cycle 5.
//   - err=1 from cycle 3 with GRANT_CHECK_EN; err=0 without.
// - T4 Multi-hot grant=0110 in IDLE.
//   - GRANT_CHECK_EN: no busy, err=1 sticky.
//   - Without: owner=0010, normal burst.
// - T5 Reset mid-burst: len3=7, grant=1000, reset pulsed at cycle 3.
//   - Expect busy/owner=0 asynchronously, no ack or done; a new grant after release is accepted normally.
// - T6 Back-to-back with arbiter model: requests from all four requesters, len=2 each.
//   - Expect grants 0001,0010,0100,1000 in rotation, ack every 4 cycles, exactly one done per burst.

Source files
------------

// File: rtl/grant_responder_pkg.sv
// Shared types and default sizes for the grant_responder slice.
package grant_responder_pkg;

    typedef enum logic [1:0] {IDLE, SERVE, ACK} resp_state_t;

    localparam int unsigned RESP_N     = 4;
    localparam int unsigned RESP_CNT_W = 4;

endpackage

// File: rtl/burst_down_counter.sv
// Loadable down-counter that tracks the remaining cycles of a burst.
module burst_down_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/grant_responder.sv
// Resource-side partner of a round-robin arbiter: latches a grant, serves a burst, pulses ack/done.
// Define GRANT_CHECK_EN to reject multi-hot grants and flag grant changes in err.
module grant_responder
    import grant_responder_pkg::*;
#(
    parameter int unsigned N     = RESP_N,
    parameter int unsigned CNT_W = RESP_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       grant,
    input  logic [N*CNT_W-1:0] burst_len,
    output logic               ack,
    output logic               busy,
    output logic [N-1:0]       owner,
    output logic [N-1:0]       done,
    output logic               err
);

    resp_state_t      state_q, state_d;
    logic [N-1:0]     owner_q, owner_d;
    logic [N-1:0]     done_q, done_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [N-1:0]     sel;
    logic [CNT_W-1:0] len_sel;
    logic [CNT_W-1:0] load_val;
    logic             multi_hot;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    // Lowest-index set bit of grant, and the burst length field it selects.
    always_comb begin
        sel     = '0;
        len_sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant[i] && (sel == '0)) begin
                sel[i]  = 1'b1;
                len_sel = burst_len[i*CNT_W +: CNT_W];
            end
        end
    end

    assign multi_hot = ((grant & (grant - N'(1))) != '0);
    assign load_val  = (len_sel == '0) ? '0 : len_sel - CNT_W'(1);

`ifdef GRANT_CHECK_EN
    assign accept = (grant != '0) && !multi_hot;
`else
    assign accept = (grant != '0);
`endif

    assign cnt_load = (state_q == IDLE) && accept;
    assign cnt_dec  = (state_q == SERVE) && !cnt_zero;

    burst_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            done_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SERVE;
            SERVE:   if (cnt_zero) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d == SERVE);
        ack_d   = (state_d == ACK);
        owner_d = owner_q;
        if (cnt_load) begin
            owner_d = sel;
        end else if (state_d != SERVE) begin
            owner_d = '0;
        end
        // owner_q is still valid on the SERVE->ACK edge, so done is taken from it there.
        done_d = ((state_q == SERVE) && cnt_zero) ? owner_q : '0;
`ifdef GRANT_CHECK_EN
        err_d = err_q
              | ((state_q == IDLE) && multi_hot)
              | ((state_q == SERVE) && (grant != owner_q));
`else
        err_d = 1'b0;
`endif
    end

    assign ack   = ack_q;
    assign busy  = busy_q;
    assign owner = owner_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_grant_responder.sv
// Self-checking bench for grant_responder: per-cycle vector table plus multi-cycle sequences.
module tb_grant_responder;

    logic        clock;
    logic        reset;
    logic [3:0]  grant;
    logic [3:0]  grant_tb;
    logic [15:0] burst_len;
    logic        ack, busy, err;
    logic [3:0]  owner, done;

    logic        arb_mode;
    logic [1:0]  ptr;
    logic [3:0]  arb_grant;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  g;
        logic [15:0] bl;
        logic        e_ack;
        logic        e_busy;
        logic [3:0]  e_owner;
        logic [3:0]  e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    grant_responder #(
        .N     (4),
        .CNT_W (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .grant     (grant),
        .burst_len (burst_len),
        .ack       (ack),
        .busy      (busy),
        .owner     (owner),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Round-robin arbiter model with all four requesters asserted.
    always @(posedge clock) begin
        if (!arb_mode) ptr <= 2'd3;
        else if (ack)  ptr <= ptr + 2'd1;
    end
    assign arb_grant = 4'b0001 << (ptr + 2'd1);
    assign grant     = arb_mode ? arb_grant : grant_tb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds grant g for the whole burst, then drops it during the ack cycle.
    task automatic run_burst(input string name, input logic [3:0] g, input logic [15:0] bl,
                             input int len);
        grant_tb  = g;
        burst_len = bl;
        for (int k = 1; k <= len; k++) begin
            step();
            check({name, " serve"}, 32'({ack, busy, owner, done}), 32'({1'b0, 1'b1, g, 4'b0}));
        end
        step();
        check({name, " ack"}, 32'({ack, busy, owner, done}), 32'({1'b1, 1'b0, 4'b0, g}));
        grant_tb = 4'b0;
        step();
        check({name, " idle"}, 32'({ack, busy, owner, done}), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        arb_mode  = 1'b0;
        grant_tb  = 4'b0;
        burst_len = 16'h7043;

        // T1: len0=3; burst_len change mid-burst must be ignored.
        vecs.push_back('{4'b0001, 16'h7043, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 16'h7041, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 16'h7041, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 16'h7043, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0});
        vecs.push_back('{4'b0000, 16'h7043, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{4'b0000, 16'h7043, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
        // T2: len2=0 behaves as one cycle.
        vecs.push_back('{4'b0100, 16'h7043, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0});
        vecs.push_back('{4'b0100, 16'h7043, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0});
        vecs.push_back('{4'b0000, 16'h7043, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
        // T4: multi-hot grant 0110, len1=4.
`ifdef GRANT_CHECK_EN
        for (int i = 0; i < 5; i++)
            vecs.push_back('{4'b0110, 16'h7043, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{4'b0000, 16'h7043, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1});
`else
        for (int i = 0; i < 4; i++)
            vecs.push_back('{4'b0110, 16'h7043, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0});
        vecs.push_back('{4'b0110, 16'h7043, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0});
        vecs.push_back('{4'b0000, 16'h7043, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
`endif

        step();
        step();
        check("reset state", 32'({ack, busy, owner, done, err}), 32'h0);
        #2 reset = 1'b0;
        step();
        check("idle after reset", 32'({ack, busy, owner, done, err}), 32'h0);

        foreach (vecs[i]) begin
            grant_tb  = vecs[i].g;
            burst_len = vecs[i].bl;
            step();
            check($sformatf("vec%0d", i), 32'({ack, busy, owner, done, err}),
                  32'({vecs[i].e_ack, vecs[i].e_busy, vecs[i].e_owner, vecs[i].e_done,
                       vecs[i].e_err}));
        end

        // T5: reset mid-burst, no ack/done for the aborted burst.
        grant_tb  = 4'b1000;
        burst_len = 16'h7043;
        step();
        check("t5 accepted", 32'({busy, owner}), 32'({1'b1, 4'b1000}));
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("t5 async clear", 32'({ack, busy, owner, done, err}), 32'h0);
        grant_tb = 4'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5 no ack", 32'({ack, busy, owner, done}), 32'h0);
        end
        run_burst("t5 regrant", 4'b0001, 16'h7043, 3);

        // T3: grant dropped in cycle 2 of a len1=4 burst.
        grant_tb = 4'b0010;
        step();
        check("t3 c1", 32'({ack, busy, owner}), 32'({1'b0, 1'b1, 4'b0010}));
        step();
        check("t3 c2", 32'({ack, busy, owner}), 32'({1'b0, 1'b1, 4'b0010}));
        grant_tb = 4'b0;
        step();
`ifdef GRANT_CHECK_EN
        check("t3 c3", 32'({ack, busy, owner, err}), 32'({1'b0, 1'b1, 4'b0010, 1'b1}));
`else
        check("t3 c3", 32'({ack, busy, owner, err}), 32'({1'b0, 1'b1, 4'b0010, 1'b0}));
`endif
        step();
        check("t3 c4", 32'({ack, busy, owner}), 32'({1'b0, 1'b1, 4'b0010}));
        step();
        check("t3 c5 ack", 32'({ack, busy, owner, done}), 32'({1'b1, 1'b0, 4'b0, 4'b0010}));
        step();
        check("t3 c6 idle", 32'({ack, busy, owner, done}), 32'h0);

        // Maximum burst length.
        run_burst("max len", 4'b0001, 16'h000F, 15);

        // T6: back-to-back with the arbiter model, len=2 each.
        burst_len = 16'h2222;
        arb_mode  = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            logic [3:0] who;
            logic       e_busy, e_ack;
            step();
            who    = 4'b0001 << (cyc / 4);
            e_busy = (cyc % 4 == 1) || (cyc % 4 == 2);
            e_ack  = (cyc % 4 == 3);
            check($sformatf("t6 c%0d", cyc), 32'({ack, busy, owner, done}),
                  32'({e_ack, e_busy, e_busy ? who : 4'b0, e_ack ? who : 4'b0}));
        end
        arb_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
